// File: rtl/i2c_report_pkg.sv
// Shared types and constants for the I2C report scheduler.
// Holds the FSM state enum, grant source encodings, status-byte bit
// positions and the tracker sample payload struct.
package i2c_report_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned TMR_W   = 16;
    localparam int unsigned SEQ_W   = 3;

    // Status byte layout
    localparam int unsigned OVF_BIT = 7;
    localparam int unsigned SEQ_LSB = 4;

    // Grant sources (also the request bit index)
    localparam logic SRC_TRK = 1'b0;
    localparam logic SRC_ST  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_LOCKED = 2'd3
    } rpt_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] x;
        logic [BYTE_W-1:0] y;
    } trk_sample_t;

endpackage

// File: rtl/report_rr_arbiter.sv
// Two-request round-robin arbiter for the report scheduler.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   req[1:0]     pending requests, index SRC_TRK / SRC_ST
//   load         capture the current pick into grant
//   advance      grant committed: point rr at the other source
//   grant        latched source being serviced
//   rr           priority pointer used when both sources request
module report_rr_arbiter
    import i2c_report_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       load,
    input  logic       advance,
    output logic       grant,
    output logic       rr
);

    logic pick_c;

    // Single requester wins outright; a tie falls back to the pointer
    always_comb begin
        pick_c = rr;
        if (req[SRC_TRK] && !req[SRC_ST]) begin
            pick_c = SRC_TRK;
        end else if (req[SRC_ST] && !req[SRC_TRK]) begin
            pick_c = SRC_ST;
        end
    end

    // Grant is held from selection until its commit so rr follows the
    // source actually committed, not whatever is requesting at that time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant <= SRC_TRK;
            rr    <= SRC_TRK;
        end else begin
            if (load) begin
                grant <= pick_c;
            end
            if (advance) begin
                rr <= ~grant;
            end
        end
    end

endmodule

// File: rtl/i2c_report_scheduler.sv
// Publishes tracker and status reports into the I2C slave's register
// bytes, never changing them while a bus transaction is in progress, and
// drives an active-low data-ready interrupt with a self-release timeout.
// Optional macro REPORT_SEQ_EN adds a 3-bit tracker-commit sequence count
// into status[6:4]; without it status[6:0] carries st_data[6:0].
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   trk_valid/trk_x/trk_y       tracker sample in (trk_ready always 1)
//   st_valid/st_data/st_ready   status word in, one staging slot
//   bus_busy, rd_done           I2C activity and end-of-read from slave
//   x_pos, y_pos, status        published bytes
//   irq_n                       data-ready interrupt, active-low
//   overflow                    sticky tracker overwrite flag
module i2c_report_scheduler
    import i2c_report_pkg::*;
#(
    parameter int unsigned IRQ_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trk_valid,
    input  logic [BYTE_W-1:0] trk_x,
    input  logic [BYTE_W-1:0] trk_y,
    output logic              trk_ready,
    input  logic              st_valid,
    input  logic [BYTE_W-1:0] st_data,
    output logic              st_ready,
    input  logic              bus_busy,
    input  logic              rd_done,
    output logic [BYTE_W-1:0] x_pos,
    output logic [BYTE_W-1:0] y_pos,
    output logic [BYTE_W-1:0] status,
    output logic              irq_n,
    output logic              overflow
);

`ifdef REPORT_SEQ_EN
    localparam int unsigned KEEP_W = SEQ_LSB;
`else
    localparam int unsigned KEEP_W = OVF_BIT;
`endif
    localparam bit TMO_EN = (IRQ_TIMEOUT != 0) && (IRQ_TIMEOUT <= ((1 << TMR_W) - 1));

    rpt_state_e        state_q, state_d;
    trk_sample_t       trk_stage;
    logic              trk_pend;
    logic [KEEP_W-1:0] st_stage, st_last, st_last_next_c;
    logic              st_pend_c, grant_load_c, commit_c;
    logic              trk_commit_c, st_commit_c, ovf_set_c;
    logic              grant, rr;
    logic [TMR_W-1:0]  tmr_q, tmr_inc_c;
    logic              tmr_hit_c;
    logic [BYTE_W-1:0] status_next_c;
    logic              unused_ok;
`ifdef REPORT_SEQ_EN
    logic [SEQ_W-1:0]  seq_q, seq_next_c;
`endif

    assign trk_ready = 1'b1;
    assign st_pend_c = !st_ready;
    assign unused_ok = ^{rr, st_data[BYTE_W-1:KEEP_W]};

    report_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({st_pend_c, trk_pend}),
        .load    (grant_load_c),
        .advance (commit_c),
        .grant   (grant),
        .rr      (rr)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any bus activity parks the FSM in LOCKED
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus_busy) begin
                    state_d = ST_LOCKED;
                end else if (trk_pend || st_pend_c) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT:  state_d = bus_busy ? ST_LOCKED : ST_COMMIT;
            ST_COMMIT: state_d = bus_busy ? ST_LOCKED : ST_IDLE;
            ST_LOCKED: begin
                if (!bus_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM strobes
    always_comb begin
        grant_load_c = 1'b0;
        commit_c     = 1'b0;
        unique case (state_q)
            ST_IDLE:   grant_load_c = !bus_busy && (trk_pend || st_pend_c);
            ST_COMMIT: commit_c     = !bus_busy;
            default:   ;
        endcase
    end

    assign trk_commit_c = commit_c && (grant == SRC_TRK);
    assign st_commit_c  = commit_c && (grant == SRC_ST);
    // Overwrite of an uncommitted sample; a same-cycle commit makes room
    assign ovf_set_c    = trk_valid && trk_pend && !trk_commit_c;
    assign st_last_next_c = st_commit_c ? st_stage : st_last;
    assign tmr_inc_c    = (tmr_q == '1) ? tmr_q : tmr_q + TMR_W'(1);
    assign tmr_hit_c    = TMO_EN && (tmr_inc_c == TMR_W'(IRQ_TIMEOUT));

`ifdef REPORT_SEQ_EN
    assign seq_next_c = seq_q + SEQ_W'(trk_commit_c);
`endif

    // Status byte image written on every commit
    always_comb begin
        status_next_c          = '0;
        status_next_c[OVF_BIT] = overflow;
`ifdef REPORT_SEQ_EN
        status_next_c[SEQ_LSB +: SEQ_W]  = seq_next_c;
        status_next_c[KEEP_W-1:0]        = st_last_next_c;
`else
        status_next_c[KEEP_W-1:0]        = st_last_next_c;
`endif
    end

    // Staging slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_stage <= '0;
            trk_pend  <= 1'b0;
            st_stage  <= '0;
            st_ready  <= 1'b1;
        end else begin
            if (trk_valid) begin
                trk_stage.x <= trk_x;
                trk_stage.y <= trk_y;
                trk_pend    <= 1'b1;
            end else if (trk_commit_c) begin
                trk_pend <= 1'b0;
            end
            if (st_valid && st_ready) begin
                st_stage <= st_data[KEEP_W-1:0];
                st_ready <= 1'b0;
            end else if (st_commit_c) begin
                st_ready <= 1'b1;
            end
        end
    end

    // Published bytes, only touched in a bus-quiet COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos   <= '0;
            y_pos   <= '0;
            status  <= '0;
            st_last <= '0;
`ifdef REPORT_SEQ_EN
            seq_q   <= '0;
`endif
        end else if (commit_c) begin
            if (trk_commit_c) begin
                x_pos <= trk_stage.x;
                y_pos <= trk_stage.y;
            end
            st_last <= st_last_next_c;
            status  <= status_next_c;
`ifdef REPORT_SEQ_EN
            seq_q   <= seq_next_c;
`endif
        end
    end

    // Overflow flag: a new overwrite beats a same-cycle read completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (ovf_set_c) begin
            overflow <= 1'b1;
        end else if (rd_done) begin
            overflow <= 1'b0;
        end
    end

    // Interrupt and self-release timer; fresh tracker data re-arms it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_n <= 1'b1;
            tmr_q <= '0;
        end else if (trk_commit_c) begin
            irq_n <= 1'b0;
            tmr_q <= '0;
        end else if (rd_done) begin
            irq_n <= 1'b1;
        end else if (!irq_n) begin
            tmr_q <= tmr_inc_c;
            if (tmr_hit_c) begin
                irq_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_report_scheduler.sv
// Self-checking bench for i2c_report_scheduler: a behavioural model of the
// publishing rules is compared against the DUT every cycle, with directed
// scenarios pinned by literal expectations and a randomized soak.
module tb_i2c_report_scheduler;

    localparam int unsigned TO = 8;
`ifdef REPORT_SEQ_EN
    localparam logic [7:0] ST_MASK = 8'h8F;
`else
    localparam logic [7:0] ST_MASK = 8'hFF;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trk_valid = 1'b0;
    logic [7:0] trk_x = 8'h00;
    logic [7:0] trk_y = 8'h00;
    logic       trk_ready;
    logic       st_valid = 1'b0;
    logic [7:0] st_data = 8'h00;
    logic       st_ready;
    logic       bus_busy = 1'b0;
    logic       rd_done = 1'b0;
    logic [7:0] x_pos, y_pos, status;
    logic       irq_n, overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_report_scheduler #(.IRQ_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trk_valid (trk_valid),
        .trk_x     (trk_x),
        .trk_y     (trk_y),
        .trk_ready (trk_ready),
        .st_valid  (st_valid),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .bus_busy  (bus_busy),
        .rd_done   (rd_done),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .status    (status),
        .irq_n     (irq_n),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, want 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An attempt needs three consecutive quiet-bus edges (select, confirm,
    // publish). Any busy edge aborts it, and the first quiet edge after
    // busy only re-arms.
    bit         m_trk_pend = 0, m_st_pend = 0;
    logic [7:0] m_trk_x = 0, m_trk_y = 0, m_st_d = 0;
    bit         m_rr = 0, m_src = 0;
    int         m_phase = 0;
    logic [7:0] m_x = 0, m_y = 0, m_status = 0;
    logic [6:0] m_st_last = 0;
    bit         m_irq = 1, m_ovf = 0;
    int         m_tmr = 0;
`ifdef REPORT_SEQ_EN
    logic [2:0] m_seq = 0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_trk_pend = 0; m_st_pend = 0; m_trk_x = 0; m_trk_y = 0; m_st_d = 0;
            m_rr = 0; m_src = 0; m_phase = 0; m_x = 0; m_y = 0; m_status = 0;
            m_st_last = 0; m_irq = 1; m_ovf = 0; m_tmr = 0;
`ifdef REPORT_SEQ_EN
            m_seq = 0;
`endif
        end else begin
            bit commit, ctrk, cst, st_acc, ovf_set;
            commit  = (m_phase == 2) && !bus_busy;
            ctrk    = commit && !m_src;
            cst     = commit && m_src;
            st_acc  = st_valid && !m_st_pend;
            ovf_set = trk_valid && m_trk_pend && !ctrk;

            if (commit) begin
                if (cst) m_st_last = m_st_d[6:0];
                if (ctrk) begin
                    m_x = m_trk_x;
                    m_y = m_trk_y;
                end
`ifdef REPORT_SEQ_EN
                if (ctrk) m_seq = m_seq + 3'd1;
                m_status = {m_ovf, m_seq, m_st_last[3:0]};
`else
                m_status = {m_ovf, m_st_last};
`endif
                m_rr = !m_src;
            end

            if (bus_busy) begin
                m_phase = -1;
            end else if (m_phase == -1) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (m_trk_pend || m_st_pend) begin
                    if (m_trk_pend && m_st_pend) m_src = m_rr;
                    else m_src = m_st_pend;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else begin
                m_phase = 0;
            end

            if (ctrk) m_trk_pend = 0;
            if (trk_valid) begin
                m_trk_x = trk_x;
                m_trk_y = trk_y;
                m_trk_pend = 1;
            end
            if (cst) m_st_pend = 0;
            if (st_acc) begin
                m_st_d = st_data;
                m_st_pend = 1;
            end

            if (ctrk) begin
                m_irq = 0;
                m_tmr = 0;
            end else if (rd_done) begin
                m_irq = 1;
            end else if (!m_irq) begin
                if (m_tmr < 65535) m_tmr++;
                if (TO != 0 && m_tmr == TO) m_irq = 1;
            end

            if (ovf_set) m_ovf = 1;
            else if (rd_done) m_ovf = 0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("x_pos", x_pos, m_x);
            check("y_pos", y_pos, m_y);
            check("status", status, m_status);
            check("irq_n", 8'(irq_n), 8'(m_irq));
            check("overflow", 8'(overflow), 8'(m_ovf));
            check("st_ready", 8'(st_ready), 8'(!m_st_pend));
            check("trk_ready", 8'(trk_ready), 8'h01);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_trk(input logic [7:0] x, input logic [7:0] y);
        trk_valid = 1'b1;
        trk_x = x;
        trk_y = y;
        @(negedge clk);
        trk_valid = 1'b0;
    endtask

    task automatic pulse_rd;
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_x", x_pos, 8'h00);
        check("rst_status", status, 8'h00);
        check("rst_irq", 8'(irq_n), 8'h01);
        check("rst_st_ready", 8'(st_ready), 8'h01);

        // Sample arrives while the bus is busy: held until it goes quiet
        bus_busy = 1'b1;
        tick(1);
        push_trk(8'h55, 8'h66);
        tick(3);
        check("busy_hold_x", x_pos, 8'h00);
        bus_busy = 1'b0;
        tick(3);
        check("busy_late_x", x_pos, 8'h00);
        tick(1);
        check("busy_pub_x", x_pos, 8'h55);
        check("busy_pub_y", y_pos, 8'h66);
        check("busy_irq", 8'(irq_n), 8'h00);
        pulse_rd();
        check("busy_rd_irq", 8'(irq_n), 8'h01);

        // Basic three-edge latency
        push_trk(8'h12, 8'h34);
        tick(2);
        check("lat_early_x", x_pos, 8'h55);
        tick(1);
        check("lat_x", x_pos, 8'h12);
        check("lat_y", y_pos, 8'h34);
        check("lat_irq", 8'(irq_n), 8'h00);
        pulse_rd();
        check("lat_rd_irq", 8'(irq_n), 8'h01);

        // Overwrite while bus busy
        bus_busy = 1'b1;
        tick(1);
        push_trk(8'h77, 8'h88);
        push_trk(8'h99, 8'hAA);
        check("ovf_set", 8'(overflow), 8'h01);
        bus_busy = 1'b0;
        tick(4);
        check("ovf_x", x_pos, 8'h99);
        check("ovf_y", y_pos, 8'hAA);
        check("ovf_status", status & ST_MASK, 8'h80);
        pulse_rd();
        check("ovf_clr", 8'(overflow), 8'h00);
        check("ovf_status_hold", status & ST_MASK, 8'h80);

        // Lone status commit leaves rr pointing at the tracker
        st_valid = 1'b1;
        st_data  = 8'h01;
        tick(1);
        st_valid = 1'b0;
        check("st_busy_slot", 8'(st_ready), 8'h00);
        tick(3);
        check("st_pub", status & ST_MASK, 8'h01);
        check("st_free", 8'(st_ready), 8'h01);

        // Both pending, rr = tracker: tracker first, then status
        trk_valid = 1'b1; trk_x = 8'hC3; trk_y = 8'h5A;
        st_valid  = 1'b1; st_data = 8'h0A;
        tick(1);
        trk_valid = 1'b0;
        st_valid  = 1'b0;
        tick(3);
        check("rr_trk_x", x_pos, 8'hC3);
        check("rr_st_wait", status & ST_MASK, 8'h01);
        check("rr_st_slot", 8'(st_ready), 8'h00);
        tick(3);
        check("rr_st_pub", status & ST_MASK, 8'h0A);
        check("rr_st_free", 8'(st_ready), 8'h01);

        // Interrupt self-release after TO cycles
        push_trk(8'h11, 8'h22);
        tick(3);
        check("tmo_low", 8'(irq_n), 8'h00);
        tick(7);
        check("tmo_still_low", 8'(irq_n), 8'h00);
        tick(1);
        check("tmo_release", 8'(irq_n), 8'h01);

        // Reset while a grant is in flight
        push_trk(8'hEE, 8'hDD);
        tick(1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_x", x_pos, 8'h00);
        check("mid_rst_y", y_pos, 8'h00);
        check("mid_rst_status", status, 8'h00);
        check("mid_rst_irq", 8'(irq_n), 8'h01);
        check("mid_rst_ovf", 8'(overflow), 8'h00);
        check("mid_rst_st_ready", 8'(st_ready), 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        check("mid_rst_discard", x_pos, 8'h00);

`ifdef REPORT_SEQ_EN
        for (int i = 0; i < 9; i++) begin
            push_trk(8'(i + 1), 8'(i + 2));
            tick(4);
        end
        check("seq_wrap", status & 8'h70, 8'h10);
`endif

        // Randomized soak against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) bus_busy = ~bus_busy;
            trk_valid = ($urandom_range(3) == 0);
            trk_x     = 8'($urandom);
            trk_y     = 8'($urandom);
            st_valid  = ($urandom_range(2) == 0);
            st_data   = 8'($urandom);
            rd_done   = ($urandom_range(15) == 0);
        end
        @(negedge clk);
        trk_valid = 1'b0;
        st_valid  = 1'b0;
        rd_done   = 1'b0;
        bus_busy  = 1'b0;
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
